// File: rtl/bsg_mux2_sel_pkg.sv
// bsg_mux2_sel_pkg: command and FSM state encodings for the select-mask sequencer
package bsg_mux2_sel_pkg;

    typedef enum logic [1:0] {
        CMD_LOAD   = 2'd0,
        CMD_SWEEP  = 2'd1,
        CMD_ROTATE = 2'd2,
        CMD_CLEAR  = 2'd3
    } cmd_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SWEEP,
        ST_ROT
    } state_e;

endpackage

// File: rtl/bsg_mux2_sel_sequencer_if.sv
// bsg_mux2_sel_sequencer_if: command handshake and select-mask outputs of the sequencer
interface bsg_mux2_sel_sequencer_if #(parameter int width_p = 16);
    import bsg_mux2_sel_pkg::*;

    logic               v_i;
    cmd_e               cmd_i;
    logic [width_p-1:0] arg_i;
    logic               ready_o;
    logic [width_p-1:0] sel_o;
    logic               busy_o;
    logic               done_o;

    modport master (output v_i, cmd_i, arg_i, input ready_o, sel_o, busy_o, done_o);
    modport slave  (input v_i, cmd_i, arg_i, output ready_o, sel_o, busy_o, done_o);

endinterface

// File: rtl/bsg_thermometer_decode.sv
// bsg_thermometer_decode: count -> mask with the low cnt_i bits set (cnt_i==width_p gives all ones)
module bsg_thermometer_decode #(
    parameter int width_p = 16,
    localparam int lg_cnt_lp = $clog2(width_p + 1)
) (
    input  logic [lg_cnt_lp-1:0] cnt_i,
    output logic [width_p-1:0]   mask_o
);

    assign mask_o = ~({width_p{1'b1}} << cnt_i);

endmodule

// File: rtl/bsg_mux2_sel_sequencer.sv
// bsg_mux2_sel_sequencer: registered select-mask generator (load / thermometer sweep / rotate / clear)
module bsg_mux2_sel_sequencer
    import bsg_mux2_sel_pkg::*;
#(
    parameter int width_p = 16
) (
    input logic                          clk_i,
    input logic                          reset_n_i,
    bsg_mux2_sel_sequencer_if.slave      bus
);

    localparam int lg_cnt_lp = $clog2(width_p + 1);

    state_e               state_q, state_d;
    logic [lg_cnt_lp-1:0] cnt_q, cnt_d;
    logic [lg_cnt_lp-1:0] tgt_q, tgt_d;
    logic [lg_cnt_lp-1:0] rem_q, rem_d;
    logic [width_p-1:0]   sel_q, sel_d;
    logic                 done_q, done_d;

    logic [lg_cnt_lp-1:0] arg_cnt, arg_tgt, step_tgt, step_cnt;
    logic [width_p-1:0]   thermo, rot;

    // Sweep target is clamped to the mask width; while sweeping the latched target is used.
    assign arg_cnt  = bus.arg_i[lg_cnt_lp-1:0];
    assign arg_tgt  = (arg_cnt > lg_cnt_lp'(width_p)) ? lg_cnt_lp'(width_p) : arg_cnt;
    assign step_tgt = (state_q == ST_SWEEP) ? tgt_q : arg_tgt;
    assign step_cnt = (step_tgt > cnt_q) ? cnt_q + lg_cnt_lp'(1)
                    : (step_tgt < cnt_q) ? cnt_q - lg_cnt_lp'(1) : cnt_q;
    assign rot      = {sel_q[width_p-2:0], sel_q[width_p-1]};

    bsg_thermometer_decode #(.width_p(width_p)) thermo_dec (
        .cnt_i  (step_cnt),
        .mask_o (thermo)
    );

    // Next-state: command accept in IDLE, one sweep/rotate step per cycle otherwise.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tgt_d   = tgt_q;
        rem_d   = rem_q;
        sel_d   = sel_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: if (bus.v_i) begin
                case (bus.cmd_i)
                    CMD_LOAD: begin
                        sel_d  = bus.arg_i;
                        done_d = 1'b1;
                    end
                    CMD_CLEAR: begin
                        sel_d  = '0;
                        cnt_d  = '0;
                        done_d = 1'b1;
                    end
                    CMD_SWEEP: begin
                        cnt_d = step_cnt;
                        sel_d = thermo;
                        tgt_d = arg_tgt;
                        if (step_cnt == arg_tgt) done_d = 1'b1;
                        else state_d = ST_SWEEP;
                    end
                    CMD_ROTATE: begin
                        if (arg_cnt != '0) sel_d = rot;
                        if (arg_cnt < lg_cnt_lp'(2)) done_d = 1'b1;
                        else begin
                            rem_d   = arg_cnt - lg_cnt_lp'(1);
                            state_d = ST_ROT;
                        end
                    end
                    default: ;
                endcase
            end
            ST_SWEEP: begin
                cnt_d = step_cnt;
                sel_d = thermo;
                if (step_cnt == tgt_q) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            ST_ROT: begin
                sel_d = rot;
                rem_d = rem_q - lg_cnt_lp'(1);
                if (rem_q == lg_cnt_lp'(1)) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, level, counters and outputs; async reset discards any command in flight.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            tgt_q   <= '0;
            rem_q   <= '0;
            sel_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tgt_q   <= tgt_d;
            rem_q   <= rem_d;
            sel_q   <= sel_d;
            done_q  <= done_d;
        end
    end

    assign bus.ready_o = (state_q == ST_IDLE);
    assign bus.busy_o  = (state_q != ST_IDLE);
    assign bus.sel_o   = sel_q;
    assign bus.done_o  = done_q;

endmodule

// File: doc/bsg_mux2_sel_sequencer.md
# bsg_mux2_sel_sequencer

Sequential select-mask generator that drives the per-bit select vector (`i2`) of the downstream `bsg_mux2_gatestack`. It accepts commands over a valid/ready handshake and updates a registered select mask. Supported updates are a direct load, a one-bit-per-cycle thermometer sweep, a rotate, and a clear. The mux stage then blends `i0`/`i1` bit by bit without glitch-prone combinational select logic.

## Interface
- `width_p`, default 16: select mask width; must match the gatestack width.
- `lg_cnt_lp`, default `$clog2(width_p+1)`: width of count/argument fields (local, not overridable).
- `clk_i`  input  1  clock.
- `reset_n_i`  input  1  asynchronous, active-low reset.
- `v_i`  input  1  command valid.
- `cmd_i`  input  2  command: 0 LOAD, 1 SWEEP, 2 ROTATE, 3 CLEAR.
- `arg_i`  input  `width_p`  LOAD: mask value. SWEEP/ROTATE: count in `arg_i[lg_cnt_lp-1:0]`.
- `ready_o`  output  1  command can be accepted; equals state==IDLE.
- `sel_o`  output  `width_p`  registered select mask to gatestack `i2`.
- `busy_o`  output  1  multi-cycle command in progress (state != IDLE).
- `done_o`  output  1  registered one-cycle pulse; `sel_o` holds the command's final value in this cycle.

## Operation
- Reset: `sel_o`=0, internal level `cnt_r`=0, state IDLE, `done_o`=0. Consequently `ready_o`=1 and `busy_o`=0.
- Accept occurs on a rising edge with `v_i & ready_o`. `v_i` while not ready is ignored; there is no queuing.
- LOAD: `sel_o` <= `arg_i`. `cnt_r` is unchanged. `done_o` pulses next cycle.
- CLEAR: `sel_o` <= 0 and `cnt_r` <= 0. `done_o` pulses next cycle.
- SWEEP:
  - target t = min(`arg_i[lg_cnt_lp-1:0]`, `width_p`).
  - Each step moves `cnt_r` one toward t and sets `sel_o` = thermo(`cnt_r`), meaning the low `cnt_r` bits are set.
  - If t==`cnt_r` at accept: `sel_o` <= thermo(`cnt_r`), done next cycle, stay IDLE. This normalises any LOADed or rotated mask.
  - If |t-`cnt_r`|==1: single step, done next cycle, stay IDLE.
  - Otherwise: step on the accept edge, go to SWEEP, step every edge. On reaching t, return to IDLE with `done_o`=1.
- ROTATE: n = `arg_i[lg_cnt_lp-1:0]`. Each step rotates `sel_o` left by 1 (MSB wraps to bit 0). `cnt_r` is unchanged.
  - n==0: no change, done next cycle.
  - n==1: one rotate, done next cycle.
  - Otherwise: state ROT with a remaining-step down-counter; return to IDLE on the last step.
  - n may exceed `width_p`; all n steps are still executed.
- FSM states: IDLE, SWEEP, ROT.
  - IDLE->SWEEP on SWEEP accept with distance ≥2.
  - IDLE->ROT on ROTATE accept with n≥2.
  - SWEEP/ROT->IDLE on the final step.
  - No other transitions.

## Timing
- Every `sel_o` change is registered; there is no combinational path from inputs to `sel_o`.
- Latency from accept edge to final `sel_o`:
  - LOAD, CLEAR, zero-step commands: 1 cycle.
  - SWEEP: max(|t-`cnt_r`|,1) cycles.
  - ROTATE: max(n,1) cycles.
- `ready_o` is low for latency-1 cycles.
- `done_o` is high in the first cycle `ready_o` returns high. A new command accepted in that cycle runs back-to-back with no bubble.
- `done_o` rises even when `sel_o` does not change (zero-step commands).
- Asynchronous reset mid-command: all registers return to reset values immediately. The command is discarded and no `done_o` is issued.
- Deassertion of `reset_n_i` is synchronised externally; the block does no reset synchronisation.

## Structure
- Package `bsg_mux2_sel_pkg`: enum for `cmd_i` encodings (LOAD/SWEEP/ROTATE/CLEAR) and FSM state enum (IDLE/SWEEP/ROT).
- Sub-module `bsg_thermometer_decode` (count -> `width_p` mask, combinational), instantiated once for the SWEEP path.
- Top level holds the FSM, `cnt_r`, the rotate down-counter, and the `sel_o`/`done_o` registers.

## Test plan
- Reset with `reset_n_i`=0, then release: `sel_o`=0x0000, `ready_o`=1, `busy_o`=0, `done_o`=0.
- LOAD 0xA5A5: next cycle `sel_o`=0xA5A5 with `done_o`=1 for one cycle. A back-to-back CLEAR in that cycle gives `sel_o`=0x0000 the following cycle.
- SWEEP 4 from `cnt_r`=0:
  - `sel_o` goes 0x0001, 0x0003, 0x0007, 0x000F; `ready_o` is low 3 cycles; `done_o` pulses with 0x000F.
  - Then SWEEP 1 gives 0x0007, 0x0003, 0x0001.
  - SWEEP 20 saturates and ends at 0xFFFF after 15 steps.
- LOAD 0x8001, then ROTATE 3: `sel_o` goes 0x0003, 0x0006, 0x000C. ROTATE 0 leaves 0x000C with `done_o` next cycle.
- Pulse `v_i` with LOAD 0x1234 while `busy_o`=1: command ignored, and the sweep/rotate sequence completes unchanged.
- Assert `reset_n_i` mid-SWEEP (level 5 of 9): `sel_o`=0 and `busy_o`=0 without waiting for a clock edge; no `done_o`. A following SWEEP 2 yields 0x0001, 0x0003.
